// File: rtl/reg_change_monitor.sv
// ---------------------------------------------------------------------------
// reg_change_monitor
//
// Watches NREGS registers of XLEN bits each. It flags any cycle-to-cycle change
// on an enabled channel and queues it as a pending event. Pending events are
// delivered one at a time over a valid/ready port, lowest channel first.
//
// Ports
//   clk        : sole clock, rising edge
//   resetn     : asynchronous active-low reset
//   Value      : flattened channel values, channel i at [i*XLEN +: XLEN]
//   Mask       : per-channel change-detection enable
//   Clear      : per-channel synchronous clear of the pending flag
//   ClearAll   : clears all pending flags, Overrun and EventCount
//   Change     : per-channel "pending or changing right now"
//   ChgValid   : an event is presented
//   ChgReady   : consumer accepts the presented event
//   ChgIdx     : channel of the presented event
//   ChgData    : latest sampled value of channel ChgIdx
//   Overrun    : sticky, a change hit a channel that was already pending
//   EventCount : accepted events, saturating
// ---------------------------------------------------------------------------
module reg_change_monitor #(
  parameter int XLEN  = 64,
  parameter int NREGS = 4,
  parameter int IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREGS*XLEN-1:0] Value,
  input  logic [NREGS-1:0]      Mask,
  input  logic [NREGS-1:0]      Clear,
  input  logic                  ClearAll,
  output logic [NREGS-1:0]      Change,
  output logic                  ChgValid,
  input  logic                  ChgReady,
  output logic [IDXW-1:0]       ChgIdx,
  output logic [XLEN-1:0]       ChgData,
  output logic                  Overrun,
  output logic [CNTW-1:0]       EventCount
);

  logic [XLEN-1:0]  prev_q [NREGS];
  logic [NREGS-1:0] local_chg;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] pop;
  logic [NREGS-1:0] clr;
  logic             overrun_q, overrun_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [IDXW-1:0]  sel_idx;
  logic             accept;

  // Previous-value snapshot: loaded every cycle, independent of Mask, so
  // re-enabling a channel never reports a stale difference.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) prev_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) prev_q[i] <= Value[i*XLEN +: XLEN];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_chan
      assign local_chg[gi] = Mask[gi] & (Value[gi*XLEN +: XLEN] != prev_q[gi]);
      assign pop[gi]       = accept & (sel_idx == IDXW'(gi));
    end
  endgenerate

  // Fixed priority: descending scan so the lowest pending index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDXW'(i);
    end
  end

  // Valid comes from registered flags only; a fresh change shows up on
  // Change immediately but is presented as an event one cycle later.
  assign ChgValid = |pending_q;
  assign ChgIdx   = sel_idx;
  assign ChgData  = prev_q[sel_idx];
  assign accept   = ChgValid & ChgReady;

  assign Change   = pending_q | local_chg;

  // A new change dominates any clear in the same cycle, so it is never lost.
  assign clr       = Clear | {NREGS{ClearAll}} | pop;
  assign pending_d = local_chg | (pending_q & ~clr);

  // Overrun only counts a change that lands on a flag which would otherwise
  // survive this cycle; a change coinciding with its own clear is not lost.
  assign overrun_d = ClearAll ? 1'b0
                              : (overrun_q | (|(local_chg & pending_q & ~clr)));

  always_comb begin
    count_d = count_q;
    if (ClearAll) begin
      count_d = '0;
    end else if (accept && !(&count_q)) begin
      count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign Overrun    = overrun_q;
  assign EventCount = count_q;

endmodule
